decode_hs: RTL and testbench
============================

Name: decode_hs

Overview:
Parametrised successor to the current decode stage. It sits between fetch and execute and replaces the stall-hold scheme with a valid/ready handshake.
- Adds U-type (lui/auipc), an illegal-opcode flag and funct fields.
- Adds an optional two-entry skid buffer, so in_ready does not depend combinationally on out_ready.
- Reads the register file combinationally and registers the decoded bundle for execute.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN; must be >= 32.
PC_W, 32, program-counter width.
REG_READY, 0, 0 = single output register; 1 = output register plus one skid entry, with in_ready driven from a flop.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  jal/branch flush from hazard unit
in_valid  in  1  fetch has an instruction
in_ready  out  1  decode accepts this cycle
in_inst  in  32  instruction word
in_pc  in  PC_W  instruction PC
rf_addr1  out  5  regfile read address 1 (combinational)
rf_addr2  out  5  regfile read address 2 (combinational)
rf_val1  in  XLEN  regfile read data 1
rf_val2  in  XLEN  regfile read data 2
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes bundle
rtype, itype, load, store, branch, jal, jalr, lui, auipc  out  1 each  one-hot class flags
illegal  out  1  unsupported opcode
imm  out  XLEN  sign-extended immediate
rs1, rs2, rd  out  5 each  register indices
rs1_val, rs2_val  out  XLEN  operand values captured at acceptance
funct3  out  3  inst[14:12]
funct7b5  out  1  inst[30]
inst_q  out  32  instruction word
pc_q  out  PC_W  instruction PC

Behaviour:
- Reset (asynchronous) / bubble state:
  - out_valid=0, itype=1, all other flags 0, illegal=0.
  - imm, rs*, rd, vals, funct fields = 0.
  - inst_q=32'h00000013, pc_q=0.
  - Skid entry empty; in_ready=1.
- Acceptance:
  - A transfer occurs when in_valid & in_ready.
  - The bundle is decoded combinationally from in_inst and registered at that edge.
  - Latency is 1 cycle, in to out_valid.
- Output consumption: out_valid & out_ready consumes the bundle. Contents of a valid, unconsumed bundle are held bit-stable.
- REG_READY=0: in_ready = ~out_valid | out_ready. This is a combinational path.
- REG_READY=1: in_ready = ~skid_valid, from a flop.
  - If the output is occupied and not consumed, an accepted instruction goes to the skid entry.
  - When the output is consumed while the skid entry is full, the skid entry moves to the output that edge, and in_ready returns to 1 the next cycle.
  - Order is preserved; there is never loss or duplication.
- Decode by opcode:
  - 0110011 rtype: rs1, rs2, rd.
  - 0010011 itype: rs1, rd, I-imm.
  - 0000011 load: rs1, rd, I-imm.
  - 0100011 store: rs1, rs2, S-imm.
  - 1100011 branch: rs1, rs2, B-imm (bit0=0).
  - 1101111 jal: rd, J-imm.
  - 1100111 jalr: rs1, rd, I-imm.
  - 0110111 lui: rd, imm={inst[31:12],12'b0} sign-extended.
  - 0010111 auipc: same immediate as lui.
- Unused rs1/rs2/rd fields are forced to 0, and rf_addr is 0 for an unused operand (value 0).
- Any other opcode, or inst[1:0]!=2'b11: illegal=1, all class flags 0, rd=0, inst_q=in_inst. The bundle still flows; it is not dropped.
- Operand values are sampled at acceptance. Writebacks occurring afterwards are the bypass network's responsibility.
- Flush, when asserted on an edge:
  - The output returns to the bubble state and the skid entry is cleared.
  - in_ready=1 that cycle and any offered instruction is dropped.
  - Flush has priority over acceptance and consumption.
- A bubble (out_valid=0) never raises a class flag other than itype.

Optional Feature:
DECODE_PERF_EN. When defined, adds:
- Output port perf_decoded (32): counts consumed bundles, excluding illegal ones.
- Output port perf_bp_cycles (32): counts cycles with in_valid & ~in_ready.

Counter rules:
- Both counters wrap at 2^32 and are cleared by rst.
- They are not cleared by flush.

When the macro is not defined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
1. Assert rst mid-stream with a full skid entry (REG_READY=1) -> same cycle: out_valid=0, inst_q=0x00000013, itype=1, in_ready=1 after release.
2. in_inst=0x00500093, pc=0x100, out_ready=1 -> next cycle: out_valid=1, itype=1, rd=1, rs1=0, rf_addr1=0, imm=5, pc_q=0x100.
3. Send 0x123450B7 (lui x1), then 0xFE208EE3 (beq x1,x2,-4):
   - lui: lui=1, imm=0x12345000, rd=1.
   - beq: branch=1, rs1=1, rs2=2, imm=0xFFFFFFFC, rd=0.
4. REG_READY=1, out_ready=0, send A,B,C back-to-back:
   - A held at output; B in skid; in_ready=0 for C.
   - Raise out_ready: output shows A, B, C in order, no duplicates.
5. Assert flush with in_valid=1 and a valid held bundle -> next cycle: out_valid=0, inst_q=0x00000013, skid empty, and the dropped instruction never appears.
6. in_inst=0x0000007F -> illegal=1, all class flags 0, out_valid=1; with DECODE_PERF_EN, perf_decoded is unchanged on consumption.

Source files
------------

// File: rtl/decode_hs_if.sv
// decode_hs_if: fetch/regfile/execute bus of the handshaked decode stage.
// Perf counter signals exist only when DECODE_PERF_EN is defined.
interface decode_hs_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic [4:0]      rf_addr1;
    logic [4:0]      rf_addr2;
    logic [XLEN-1:0] rf_val1;
    logic [XLEN-1:0] rf_val2;
    logic            out_valid;
    logic            out_ready;
    logic            rtype, itype, load, store, branch, jal, jalr, lui, auipc;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [31:0]     inst_q;
    logic [PC_W-1:0] pc_q;
`ifdef DECODE_PERF_EN
    logic [31:0]     perf_decoded;
    logic [31:0]     perf_bp_cycles;
`endif

    modport slave (
        input  flush, in_valid, in_inst, in_pc, rf_val1, rf_val2, out_ready,
        output in_ready, rf_addr1, rf_addr2, out_valid,
        output rtype, itype, load, store, branch, jal, jalr, lui, auipc, illegal,
        output imm, rs1, rs2, rd, rs1_val, rs2_val, funct3, funct7b5, inst_q, pc_q
`ifdef DECODE_PERF_EN
        , output perf_decoded, perf_bp_cycles
`endif
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, rf_val1, rf_val2, out_ready,
        input  in_ready, rf_addr1, rf_addr2, out_valid,
        input  rtype, itype, load, store, branch, jal, jalr, lui, auipc, illegal,
        input  imm, rs1, rs2, rd, rs1_val, rs2_val, funct3, funct7b5, inst_q, pc_q
`ifdef DECODE_PERF_EN
        , input perf_decoded, perf_bp_cycles
`endif
    );
endinterface

// File: rtl/decode_hs.sv
// decode_hs: RV32 decode stage with valid/ready handshake and optional skid entry.
// Optional perf counters enabled by DECODE_PERF_EN.
module decode_hs #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter bit REG_READY = 1'b0
) (
    input logic        clk,
    input logic        rst,
    decode_hs_if.slave bus
);
    typedef struct packed {
        logic            rtype, itype, load, store, branch, jal, jalr, lui, auipc, illegal;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] rs1_val, rs2_val;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } bundle_t;

    localparam bundle_t BUBBLE = '{itype: 1'b1, inst: 32'h0000_0013, default: '0};

    bundle_t         dec, out_q, out_d, skid_q, skid_d;
    logic            out_v_q, out_v_d, skid_v_q, skid_v_d;
    logic            use1, use2, used;
    logic            acc;
    logic [6:0]      op;
    logic [31:0]     ins;
    logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm;

    assign ins   = bus.in_inst;
    assign op    = ins[6:0];
    assign i_imm = XLEN'($signed(ins[31:20]));
    assign s_imm = XLEN'($signed({ins[31:25], ins[11:7]}));
    assign b_imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign j_imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    assign u_imm = XLEN'($signed({ins[31:12], 12'b0}));

    // Opcode compare covers inst[1:0], so a non-11 low pair falls out as illegal.
    always_comb begin
        dec          = '0;
        dec.rtype    = op == 7'b0110011;
        dec.itype    = op == 7'b0010011;
        dec.load     = op == 7'b0000011;
        dec.store    = op == 7'b0100011;
        dec.branch   = op == 7'b1100011;
        dec.jal      = op == 7'b1101111;
        dec.jalr     = op == 7'b1100111;
        dec.lui      = op == 7'b0110111;
        dec.auipc    = op == 7'b0010111;
        dec.illegal  = ~(dec.rtype | dec.itype | dec.load | dec.store | dec.branch |
                         dec.jal | dec.jalr | dec.lui | dec.auipc);
        use1         = dec.rtype | dec.itype | dec.load | dec.store | dec.branch | dec.jalr;
        use2         = dec.rtype | dec.store | dec.branch;
        used         = dec.rtype | dec.itype | dec.load | dec.jal | dec.jalr | dec.lui | dec.auipc;
        dec.imm      = (dec.itype | dec.load | dec.jalr) ? i_imm :
                       dec.store                       ? s_imm :
                       dec.branch                      ? b_imm :
                       dec.jal                         ? j_imm :
                       (dec.lui | dec.auipc)           ? u_imm : '0;
        dec.rs1      = use1 ? ins[19:15] : 5'd0;
        dec.rs2      = use2 ? ins[24:20] : 5'd0;
        dec.rd       = used ? ins[11:7] : 5'd0;
        dec.rs1_val  = use1 ? bus.rf_val1 : '0;
        dec.rs2_val  = use2 ? bus.rf_val2 : '0;
        dec.funct3   = ins[14:12];
        dec.funct7b5 = ins[30];
        dec.inst     = ins;
        dec.pc       = bus.in_pc;
    end

    assign bus.rf_addr1 = dec.rs1;
    assign bus.rf_addr2 = dec.rs2;
    assign bus.in_ready = REG_READY ? ~skid_v_q : (~out_v_q | bus.out_ready | bus.flush);
    assign acc          = bus.in_valid & bus.in_ready;

    // A consumed bundle with nothing behind it reverts to the bubble encoding.
    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (bus.flush) begin
            out_d    = BUBBLE;
            out_v_d  = 1'b0;
            skid_d   = BUBBLE;
            skid_v_d = 1'b0;
        end else if (~out_v_q | bus.out_ready) begin
            if (REG_READY && skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_d   = BUBBLE;
                skid_v_d = 1'b0;
            end else if (acc) begin
                out_d   = dec;
                out_v_d = 1'b1;
            end else begin
                out_d   = BUBBLE;
                out_v_d = 1'b0;
            end
        end else if (REG_READY && acc) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= BUBBLE;
            out_v_q  <= 1'b0;
            skid_q   <= BUBBLE;
            skid_v_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign bus.out_valid = out_v_q;
    assign bus.rtype     = out_q.rtype;
    assign bus.itype     = out_q.itype;
    assign bus.load      = out_q.load;
    assign bus.store     = out_q.store;
    assign bus.branch    = out_q.branch;
    assign bus.jal       = out_q.jal;
    assign bus.jalr      = out_q.jalr;
    assign bus.lui       = out_q.lui;
    assign bus.auipc     = out_q.auipc;
    assign bus.illegal   = out_q.illegal;
    assign bus.imm       = out_q.imm;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.rs1_val   = out_q.rs1_val;
    assign bus.rs2_val   = out_q.rs2_val;
    assign bus.funct3    = out_q.funct3;
    assign bus.funct7b5  = out_q.funct7b5;
    assign bus.inst_q    = out_q.inst;
    assign bus.pc_q      = out_q.pc;

`ifdef DECODE_PERF_EN
    logic [31:0] perf_dec_q, perf_dec_d, perf_bp_q, perf_bp_d;

    assign perf_dec_d = perf_dec_q + 32'(out_v_q & bus.out_ready & ~bus.flush & ~out_q.illegal);
    assign perf_bp_d  = perf_bp_q + 32'(bus.in_valid & ~bus.in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dec_q <= '0;
            perf_bp_q  <= '0;
        end else begin
            perf_dec_q <= perf_dec_d;
            perf_bp_q  <= perf_bp_d;
        end
    end

    assign bus.perf_decoded   = perf_dec_q;
    assign bus.perf_bp_cycles = perf_bp_q;
`endif
endmodule

// File: tb/tb_decode_hs.sv
// tb_decode_hs: randomized scoreboard bench for decode_hs with skid entry enabled.
module tb_decode_hs;
    typedef struct packed {
        logic        rtype, itype, load, store, branch, jal, jalr, lui, auipc, illegal;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] regs [32];
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    decode_hs_if #(.XLEN(32), .PC_W(32)) bus ();
    decode_hs #(.XLEN(32), .PC_W(32), .REG_READY(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rf_val1 = regs[bus.rf_addr1];
    assign bus.rf_val2 = regs[bus.rf_addr2];

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t   e;
        bit     u1, u2, ud;
        longint v;
        e = '0; u1 = 0; u2 = 0; ud = 0; v = 0;
        case (i[6:0])
            7'b0110011: begin e.rtype = 1; u1 = 1; u2 = 1; ud = 1; end
            7'b0010011: begin e.itype = 1; u1 = 1; ud = 1; v = $signed(i[31:20]); end
            7'b0000011: begin e.load = 1; u1 = 1; ud = 1; v = $signed(i[31:20]); end
            7'b0100011: begin e.store = 1; u1 = 1; u2 = 1; v = $signed({i[31:25], i[11:7]}); end
            7'b1100011: begin e.branch = 1; u1 = 1; u2 = 1; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
            7'b1101111: begin e.jal = 1; ud = 1; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
            7'b1100111: begin e.jalr = 1; u1 = 1; ud = 1; v = $signed(i[31:20]); end
            7'b0110111: begin e.lui = 1; ud = 1; v = $signed({i[31:12], 12'b0}); end
            7'b0010111: begin e.auipc = 1; ud = 1; v = $signed({i[31:12], 12'b0}); end
            default:    e.illegal = 1;
        endcase
        e.imm  = v[31:0];
        e.rs1  = u1 ? i[19:15] : 5'd0;
        e.rs2  = u2 ? i[24:20] : 5'd0;
        e.rd   = ud ? i[11:7] : 5'd0;
        e.v1   = u1 ? regs[i[19:15]] : 32'd0;
        e.v2   = u2 ? regs[i[24:20]] : 32'd0;
        e.f3   = i[14:12];
        e.f7   = i[30];
        e.inst = i;
        e.pc   = pc;
        return e;
    endfunction

    function automatic exp_t act();
        exp_t a;
        a = '{bus.rtype, bus.itype, bus.load, bus.store, bus.branch, bus.jal, bus.jalr,
              bus.lui, bus.auipc, bus.illegal, bus.imm, bus.rs1, bus.rs2, bus.rd,
              bus.rs1_val, bus.rs2_val, bus.funct3, bus.funct7b5, bus.inst_q, bus.pc_q};
        return a;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Scoreboard monitor: checks held output against queue head, records transfers.
    always @(negedge clk) begin
        if (rst || bus.flush) q.delete();
        else begin
            tests++;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out: got inst=%h with empty scoreboard", bus.inst_q);
                end else if (act() !== q[0]) begin
                    fails++;
                    $display("FAIL bundle: got %h expected %h", act(), q[0]);
                end
                if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            end else if ({bus.rtype, bus.itype, bus.load, bus.store, bus.branch, bus.jal,
                          bus.jalr, bus.lui, bus.auipc, bus.illegal} !== 10'b01_0000_0000) begin
                fails++;
                $display("FAIL bubble_flags: got %b expected 0100000000",
                         {bus.rtype, bus.itype, bus.load, bus.store, bus.branch, bus.jal,
                          bus.jalr, bus.lui, bus.auipc, bus.illegal});
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_inst, bus.in_pc));
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] pc);
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_inst  = i;
        bus.in_pc    = pc;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  ops [10];
        logic [31:0] perf0;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        perf0 = 0;
        for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 32'd0 : $urandom();
        bus.flush = 0; bus.in_valid = 0; bus.in_inst = 32'h13; bus.in_pc = 0; bus.out_ready = 0;
        cyc(2);
        rst = 1'b0;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_inst_q", 64'(bus.inst_q), 64'h13);

        // Reset mid-stream with a full skid entry
        send(32'h0010_0113, 32'h10);
        send(32'h0020_0193, 32'h14);
        chk("skid_full_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_inst_q", 64'(bus.inst_q), 64'h13);
        chk("rst_itype", 64'(bus.itype), 64'd1);
        cyc(1);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 64'(bus.in_ready), 64'd1);

        // addi x1, x0, 5
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_inst = 32'h0050_0093; #1;
        chk("addi_rf_addr1", 64'(bus.rf_addr1), 64'd0);
        send(32'h0050_0093, 32'h100);
        chk("addi_valid", 64'(bus.out_valid), 64'd1);
        chk("addi_itype", 64'(bus.itype), 64'd1);
        chk("addi_rd", 64'(bus.rd), 64'd1);
        chk("addi_rs1", 64'(bus.rs1), 64'd0);
        chk("addi_imm", 64'(bus.imm), 64'd5);
        chk("addi_pc", 64'(bus.pc_q), 64'h100);

        send(32'h1234_50B7, 32'h104);
        chk("lui_flag", 64'(bus.lui), 64'd1);
        chk("lui_imm", 64'(bus.imm), 64'h1234_5000);
        chk("lui_rd", 64'(bus.rd), 64'd1);
        send(32'hFE20_8EE3, 32'h108);
        chk("beq_flag", 64'(bus.branch), 64'd1);
        chk("beq_regs", 64'({bus.rs1, bus.rs2, bus.rd}), 64'({5'd1, 5'd2, 5'd0}));
        chk("beq_imm", 64'(bus.imm), 64'hFFFF_FFFC);
        chk("beq_vals", 64'({bus.rs1_val, bus.rs2_val}), {regs[1], regs[2]});

        // Back-to-back A, B, C with execute stalled
        cyc(2);
        bus.out_ready = 1'b0;
        send(32'h00A0_0513, 32'h200);
        send(32'h00B0_0593, 32'h204);
        bus.in_valid = 1'b1; bus.in_inst = 32'h00C0_0613; bus.in_pc = 32'h208;
        @(negedge clk);
        chk("abc_c_blocked", 64'(bus.in_ready), 64'd0);
        chk("abc_a_held", 64'(bus.inst_q), 64'h00A0_0513);
        cyc(1);
        bus.out_ready = 1'b1;
        send(32'h00C0_0613, 32'h208);
        cyc(4);
        chk("abc_drained", 64'(q.size()), 64'd0);

        // Flush drops a held bundle and the offered instruction
        bus.out_ready = 1'b0;
        send(32'h00D0_0693, 32'h300);
        bus.in_valid = 1'b1; bus.in_inst = 32'h00E0_0713; bus.in_pc = 32'h304; bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_inst_q", 64'(bus.inst_q), 64'h13);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        cyc(3);
        chk("flush_no_leak", 64'(bus.out_valid), 64'd0);

        // Illegal opcode still flows
`ifdef DECODE_PERF_EN
        perf0 = bus.perf_decoded;
`endif
        send(32'h0000_007F, 32'h400);
        chk("ill_flag", 64'(bus.illegal), 64'd1);
        chk("ill_valid", 64'(bus.out_valid), 64'd1);
        chk("ill_classes", 64'({bus.rtype, bus.itype, bus.load, bus.store, bus.branch,
                                bus.jal, bus.jalr, bus.lui, bus.auipc}), 64'd0);
        cyc(2);
`ifdef DECODE_PERF_EN
        chk("ill_perf", 64'(bus.perf_decoded), 64'(perf0));
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom();
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.in_inst   = {r[31:7], (r[3:0] < 4'd10) ? ops[r[3:0]] : 7'(r[6:0] ^ r[13:7])};
            bus.in_pc     = $urandom();
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.flush     = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(1, 31)] = $urandom();
            cyc(1);
        end
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        cyc(6);
        chk("final_drain", 64'(q.size()), 64'd0);
        chk("final_idle", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
